// File: rtl/axil_master_seq.sv
// AXI4-Lite master sequencer: writes TXN_NUM words from BASE_ADDR, reads them back and compares each one.
// Latency: a start edge raises awvalid/wvalid two edges later; each write costs 3 cycles, each read 2, DONE 1.
// Backpressure: every valid is held until its ready; an optional watchdog (AXIL_SEQ_TIMEOUT_EN) abandons a stalled handshake.
module axil_master_seq #(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                TXN_NUM     = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(32'h4000_0000),
  parameter logic [31:0]       DATA_SEED   = 32'hA5A5_0000,
  parameter int                TIMEOUT_CYC = 1024
) (
  input  logic                  m_axi_aclk,
  input  logic                  m_axi_aresetn,
  input  logic                  init_axi_txn,
  output logic [ADDR_W-1:0]     m_axi_awaddr,
  output logic [2:0]            m_axi_awprot,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_W-1:0]     m_axi_wdata,
  output logic [DATA_W/8-1:0]   m_axi_wstrb,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic [ADDR_W-1:0]     m_axi_araddr,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [DATA_W-1:0]     m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  output logic                  busy,
  output logic                  txn_done,
  output logic                  error,
  output logic                  timeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_ADDR,
    S_WR_RESP,
    S_RD_ADDR,
    S_RD_DATA,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] STRIDE   = ADDR_W'(DATA_W / 8);
  localparam logic [7:0]        LAST_IDX = 8'(TXN_NUM - 1);

  function automatic logic [ADDR_W-1:0] addr_of(input logic [7:0] idx);
    return BASE_ADDR + ADDR_W'(idx) * STRIDE;
  endfunction

  // The pattern is a 32-bit sum, zero-extended when the bus is 64 bits wide.
  function automatic logic [DATA_W-1:0] data_of(input logic [7:0] idx);
    logic [31:0] sum;
    sum = DATA_SEED + {24'd0, idx};
    return DATA_W'(sum);
  endfunction

  state_t              state_q, state_d;
  logic [7:0]          idx_q, idx_d;
  logic [7:0]          idx_nxt;
  logic                init_q;
  logic                start_q, start_d;
  logic                start;
  logic                awvalid_q, awvalid_d;
  logic                wvalid_q, wvalid_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;
  logic                bready_q, bready_d;
  logic                arvalid_q, arvalid_d;
  logic                rready_q, rready_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
  logic [ADDR_W-1:0]   araddr_q, araddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;

  // Only bit 1 of a response (SLVERR/DECERR) marks a failure; the OKAY/EXOKAY bit is ignored.
  logic unused_resp;
  assign unused_resp = &{1'b0, m_axi_bresp[0], m_axi_rresp[0]};

`ifdef AXIL_SEQ_TIMEOUT_EN
  localparam int              WDT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(TIMEOUT_CYC - 1);
  logic [WDT_W-1:0] wdt_q, wdt_d;
  logic             timeout_q, timeout_d;
  logic             wait_st;
  assign wait_st = (state_q == S_WR_ADDR) || (state_q == S_WR_RESP) ||
                   (state_q == S_RD_ADDR) || (state_q == S_RD_DATA);
`endif

  // Rising edge of the start request; init_q resets to 0 so a level held through reset still counts.
  assign start   = init_axi_txn & ~init_q;
  assign idx_nxt = idx_q + 8'd1;

  // Next-state and next-output computation for the whole sequencer.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    start_d   = 1'b0;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    bready_d  = bready_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    error_d   = error_q;
    awaddr_d  = awaddr_q;
    araddr_d  = araddr_q;
    wdata_d   = wdata_q;

    case (state_q)
      S_IDLE: begin
        start_d = start & ~start_q;
        if (start_q) begin
          state_d   = S_WR_ADDR;
          idx_d     = 8'd0;
          error_d   = 1'b0;
          busy_d    = 1'b1;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          awaddr_d  = addr_of(8'd0);
          wdata_d   = data_of(8'd0);
        end
      end
      S_WR_ADDR: begin
        if (awvalid_q && m_axi_awready) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (wvalid_q && m_axi_wready) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        // Both channels have completed on earlier edges, in any order.
        if (aw_done_q && w_done_q) begin
          state_d  = S_WR_RESP;
          bready_d = 1'b1;
        end
      end
      S_WR_RESP: begin
        if (m_axi_bvalid) begin
          bready_d = 1'b0;
          if (m_axi_bresp[1]) error_d = 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d   = S_RD_ADDR;
            idx_d     = 8'd0;
            arvalid_d = 1'b1;
            araddr_d  = addr_of(8'd0);
          end else begin
            state_d   = S_WR_ADDR;
            idx_d     = idx_nxt;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            awaddr_d  = addr_of(idx_nxt);
            wdata_d   = data_of(idx_nxt);
          end
        end
      end
      S_RD_ADDR: begin
        if (m_axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_RD_DATA;
        end
      end
      S_RD_DATA: begin
        if (m_axi_rvalid) begin
          rready_d = 1'b0;
          if (m_axi_rresp[1] || (m_axi_rdata != data_of(idx_q))) error_d = 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d   = S_RD_ADDR;
            idx_d     = idx_nxt;
            arvalid_d = 1'b1;
            araddr_d  = addr_of(idx_nxt);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

`ifdef AXIL_SEQ_TIMEOUT_EN
    timeout_d = timeout_q;
    if (state_q == S_IDLE && start_q) timeout_d = 1'b0;
    wdt_d = '0;
    // Count cycles stuck in one wait state; leaving the state restarts the count.
    if (wait_st && (state_d == state_q)) begin
      if (wdt_q == WDT_LAST) begin
        timeout_d = 1'b1;
        error_d   = 1'b1;
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        bready_d  = 1'b0;
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
        state_d   = S_DONE;
        done_d    = 1'b1;
      end else begin
        wdt_d = wdt_q + WDT_W'(1);
      end
    end
`endif
  end

  // State and registered outputs; asynchronous reset returns to IDLE with all handshakes idle.
  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      state_q   <= S_IDLE;
      idx_q     <= 8'd0;
      init_q    <= 1'b0;
      start_q   <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      awaddr_q  <= '0;
      araddr_q  <= '0;
      wdata_q   <= '0;
`ifdef AXIL_SEQ_TIMEOUT_EN
      wdt_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      init_q    <= init_axi_txn;
      start_q   <= start_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
      awaddr_q  <= awaddr_d;
      araddr_q  <= araddr_d;
      wdata_q   <= wdata_d;
`ifdef AXIL_SEQ_TIMEOUT_EN
      wdt_q     <= wdt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = '1;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;
  assign busy          = busy_q;
  assign txn_done      = done_q;
  assign error         = error_q;
`ifdef AXIL_SEQ_TIMEOUT_EN
  assign timeout       = timeout_q;
`else
  assign timeout       = 1'b0;
`endif

endmodule

// File: tb/tb_axil_master_seq.sv
// Directed bench for axil_master_seq: a scripted AXI4-Lite slave with per-test knobs.
// Timing: outputs sampled on the falling edge, inputs driven there too.
// Slave readiness is set per step to exercise skew, error and reset cases.
module tb_axil_master_seq;

  logic        clk;
  logic        arst_n;
  logic        init;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready;
  logic [1:0]  bresp, rresp;
  logic        bvalid, bready, arvalid, arready, rvalid, rready;
  logic        busy, txn_done, error, timeout;

  logic        wr_err;
  logic        rd_bad;
  logic [31:0] mem [4];
  logic [31:0] aw_log [64];
  logic [31:0] w_log  [64];
  logic [31:0] ar_log [64];
  int          n_aw = 0;
  int          n_w  = 0;
  int          n_ar = 0;
  int          n_assert = 0;
  int          n_fail = 0;
  logic [31:0] exp_addr [4];
  logic [31:0] exp_data [4];

  axil_master_seq #(.TIMEOUT_CYC(16)) dut (
    .m_axi_aclk    (clk),
    .m_axi_aresetn (arst_n),
    .init_axi_txn  (init),
    .m_axi_awaddr  (awaddr),
    .m_axi_awprot  (awprot),
    .m_axi_awvalid (awvalid),
    .m_axi_awready (awready),
    .m_axi_wdata   (wdata),
    .m_axi_wstrb   (wstrb),
    .m_axi_wvalid  (wvalid),
    .m_axi_wready  (wready),
    .m_axi_bresp   (bresp),
    .m_axi_bvalid  (bvalid),
    .m_axi_bready  (bready),
    .m_axi_araddr  (araddr),
    .m_axi_arprot  (arprot),
    .m_axi_arvalid (arvalid),
    .m_axi_arready (arready),
    .m_axi_rdata   (rdata),
    .m_axi_rresp   (rresp),
    .m_axi_rvalid  (rvalid),
    .m_axi_rready  (rready),
    .busy          (busy),
    .txn_done      (txn_done),
    .error         (error),
    .timeout       (timeout)
  );

  always #5 clk = ~clk;

  // Slave: SLVERR on the second write when armed, echo of stored data with optional corruption of word 1.
  assign bresp = (wr_err && awaddr == 32'h4000_0004) ? 2'b10 : 2'b00;
  assign rdata = (rd_bad && araddr == 32'h4000_0004) ? 32'hDEAD_BEEF : mem[araddr[3:2]];

  // Record every handshake the master completes.
  always @(posedge clk) begin
    if (awvalid && awready) begin
      aw_log[n_aw[5:0]] <= awaddr;
      n_aw <= n_aw + 1;
    end
    if (wvalid && wready) begin
      w_log[n_w[5:0]] <= wdata;
      mem[awaddr[3:2]] <= wdata;
      n_w <= n_w + 1;
    end
    if (arvalid && arready) begin
      ar_log[n_ar[5:0]] <= araddr;
      n_ar <= n_ar + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called on a falling edge; leaves the bench on the first cycle with awvalid high.
  task automatic start_seq(input string tag);
    init = 1'b1;
    @(negedge clk);
    chk({tag, "_awvalid_edgeN"}, 64'(awvalid), 64'd0);
    chk({tag, "_busy_edgeN"}, 64'(busy), 64'd0);
    init = 1'b0;
    @(negedge clk);
    chk({tag, "_awvalid_c0"}, 64'(awvalid), 64'd1);
    chk({tag, "_wvalid_c0"}, 64'(wvalid), 64'd1);
    chk({tag, "_busy_c0"}, 64'(busy), 64'd1);
    chk({tag, "_awaddr_c0"}, 64'(awaddr), 64'h4000_0000);
    chk({tag, "_wdata_c0"}, 64'(wdata), 64'hA5A5_0000);
    chk({tag, "_error_cleared"}, 64'(error), 64'd0);
  endtask

  // Walk the sequence from cycle k0, recording when txn_done and error first appear.
  task automatic run_seq(input int k0, input bit toggle,
                         output int dc, output int ec, output int nd,
                         output int bd, output int ba);
    int k;
    k = k0; dc = -1; ec = -1; nd = 0; bd = -1; ba = -1;
    forever begin
      if (txn_done) begin
        nd++;
        if (dc < 0) begin
          dc = k;
          bd = int'(busy);
        end
      end
      if (dc >= 0 && k == dc + 1) ba = int'(busy);
      if (error && ec < 0) ec = k;
      if (dc >= 0 && k >= dc + 3) break;
      if (k >= k0 + 300) break;
      if (toggle && k >= 3 && k <= 8) init = ~init;
      @(negedge clk);
      k++;
    end
  endtask

  initial begin
    int dc, ec, nd, bd, ba;
    int b_aw, b_w, b_ar;
    int found, cnt_done, cnt_busy;
    exp_addr[0] = 32'h4000_0000; exp_addr[1] = 32'h4000_0004;
    exp_addr[2] = 32'h4000_0008; exp_addr[3] = 32'h4000_000C;
    exp_data[0] = 32'hA5A5_0000; exp_data[1] = 32'hA5A5_0001;
    exp_data[2] = 32'hA5A5_0002; exp_data[3] = 32'hA5A5_0003;
    for (int j = 0; j < 4; j++) mem[j] = 32'd0;
    clk = 1'b0; arst_n = 1'b0; init = 1'b0;
    awready = 1'b1; wready = 1'b1; bvalid = 1'b1;
    arready = 1'b1; rvalid = 1'b1; rresp = 2'b00;
    wr_err = 1'b0; rd_bad = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_awvalid", 64'(awvalid), 64'd0);
    chk("rst_wvalid", 64'(wvalid), 64'd0);
    chk("rst_bready", 64'(bready), 64'd0);
    chk("rst_arvalid", 64'(arvalid), 64'd0);
    chk("rst_rready", 64'(rready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(txn_done), 64'd0);
    chk("rst_error", 64'(error), 64'd0);
    chk("rst_timeout", 64'(timeout), 64'd0);
    chk("rst_awaddr", 64'(awaddr), 64'd0);
    chk("rst_araddr", 64'(araddr), 64'd0);
    chk("rst_wdata", 64'(wdata), 64'd0);
    chk("rst_wstrb", 64'(wstrb), 64'hF);
    chk("rst_prot", 64'({awprot, arprot}), 64'd0);
    arst_n = 1'b1;
    @(negedge clk);

    // Zero-wait sequence: 3*4 + 2*4 cycles then DONE at cycle 20
    b_aw = n_aw; b_w = n_w; b_ar = n_ar;
    start_seq("t1");
    run_seq(0, 1'b0, dc, ec, nd, bd, ba);
    chk("t1_done_cycle", 64'(dc), 64'd20);
    chk("t1_done_pulses", 64'(nd), 64'd1);
    chk("t1_busy_in_done", 64'(bd), 64'd1);
    chk("t1_busy_after_done", 64'(ba), 64'd0);
    chk("t1_error", 64'(error), 64'd0);
    chk("t1_timeout", 64'(timeout), 64'd0);
    chk("t1_n_aw", 64'(n_aw - b_aw), 64'd4);
    chk("t1_n_w", 64'(n_w - b_w), 64'd4);
    chk("t1_n_ar", 64'(n_ar - b_ar), 64'd4);
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("t1_awaddr%0d", j), 64'(aw_log[b_aw + j]), 64'(exp_addr[j]));
      chk($sformatf("t1_wdata%0d", j), 64'(w_log[b_w + j]), 64'(exp_data[j]));
      chk($sformatf("t1_araddr%0d", j), 64'(ar_log[b_ar + j]), 64'(exp_addr[j]));
    end

    // Skewed AW/W: awready low for 5 cycles, wready high
    awready = 1'b0;
    start_seq("t2");
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) chk("t2_wvalid_dropped", 64'(wvalid), 64'd0);
      chk($sformatf("t2_awvalid_held%0d", k), 64'(awvalid), 64'd1);
      chk($sformatf("t2_awaddr_stable%0d", k), 64'(awaddr), 64'h4000_0000);
      if (k == 5) awready = 1'b1;
    end
    @(negedge clk);
    chk("t2_awvalid_dropped", 64'(awvalid), 64'd0);
    chk("t2_bready_not_yet", 64'(bready), 64'd0);
    @(negedge clk);
    chk("t2_bready_in_resp", 64'(bready), 64'd1);
    run_seq(7, 1'b0, dc, ec, nd, bd, ba);
    chk("t2_done_cycle", 64'(dc), 64'd25);
    chk("t2_error", 64'(error), 64'd0);

    // SLVERR on the second write: error visible right after its B handshake
    wr_err = 1'b1;
    b_ar = n_ar;
    start_seq("t3");
    run_seq(0, 1'b0, dc, ec, nd, bd, ba);
    chk("t3_error_cycle", 64'(ec), 64'd6);
    chk("t3_done_cycle", 64'(dc), 64'd20);
    chk("t3_reads_issued", 64'(n_ar - b_ar), 64'd4);
    chk("t3_error_sticky", 64'(error), 64'd1);
    wr_err = 1'b0;

    // Read mismatch on word 1; start also clears the previous error
    rd_bad = 1'b1;
    start_seq("t4");
    run_seq(0, 1'b0, dc, ec, nd, bd, ba);
    chk("t4_error_cycle", 64'(ec), 64'd16);
    chk("t4_done_cycle", 64'(dc), 64'd20);
    chk("t4_done_pulses", 64'(nd), 64'd1);
    rd_bad = 1'b0;

    // Start toggled while busy is ignored
    b_aw = n_aw;
    start_seq("t5");
    run_seq(0, 1'b1, dc, ec, nd, bd, ba);
    chk("t5_done_cycle", 64'(dc), 64'd20);
    chk("t5_done_pulses", 64'(nd), 64'd1);
    chk("t5_error", 64'(error), 64'd0);
    repeat (5) @(negedge clk);
    chk("t5_no_restart_busy", 64'(busy), 64'd0);
    chk("t5_no_extra_writes", 64'(n_aw - b_aw), 64'd4);

    // Reset pulsed during RD_DATA
    start_seq("t6");
    found = 0;
    for (int k = 0; k < 100 && found == 0; k++) begin
      if (rready) found = 1;
      else @(negedge clk);
    end
    chk("t6_reached_rd_data", 64'(found), 64'd1);
    arst_n = 1'b0;
    #1;
    chk("t6_awvalid", 64'(awvalid), 64'd0);
    chk("t6_wvalid", 64'(wvalid), 64'd0);
    chk("t6_bready", 64'(bready), 64'd0);
    chk("t6_arvalid", 64'(arvalid), 64'd0);
    chk("t6_rready", 64'(rready), 64'd0);
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_addrs", 64'({awaddr, araddr}), 64'd0);
    chk("t6_wdata", 64'(wdata), 64'd0);
    repeat (2) @(negedge clk);
    arst_n = 1'b1;
    cnt_done = 0; cnt_busy = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (txn_done) cnt_done++;
      if (busy) cnt_busy++;
    end
    chk("t6_no_done", 64'(cnt_done), 64'd0);
    chk("t6_stays_idle", 64'(cnt_busy), 64'd0);

`ifdef AXIL_SEQ_TIMEOUT_EN
    // Watchdog: bvalid never returned
    bvalid = 1'b0;
    start_seq("t7");
    found = -1;
    for (int k = 0; k < 100 && found < 0; k++) begin
      if (bready) found = k;
      else @(negedge clk);
    end
    chk("t7_reached_wr_resp", 64'(found >= 0), 64'd1);
    dc = -1;
    for (int k = 0; k < 100 && dc < 0; k++) begin
      if (txn_done) dc = k;
      else @(negedge clk);
    end
    chk("t7_done_after_resp", 64'(dc), 64'd16);
    chk("t7_timeout", 64'(timeout), 64'd1);
    chk("t7_error", 64'(error), 64'd1);
    chk("t7_bready_dropped", 64'(bready), 64'd0);
    bvalid = 1'b1;
    repeat (3) @(negedge clk);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
